// File: rtl/core_pkg.sv
// Shared definitions for the LEGv8 pipeline front end: widths, instruction
// size and the fetch controller state encoding.
package core_pkg;

    localparam int PC_W_DEF    = 64;
    localparam int INSTR_W_DEF = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        KILL = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a one-entry skid buffer. A word pushed while
// decode is stalled on a live instruction parks in the skid and is moved into
// IF/ID ahead of any newer word once the stall releases.
module if_id_skid
    import core_pkg::*;
#(
    parameter int DW = PC_W_DEF + INSTR_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] data_in,
    input  logic          stall,
    input  logic          flush,
    output logic          valid,
    output logic [DW-1:0] data_out,
    output logic          skid_full
);

    logic          valid_q, valid_d;
    logic [DW-1:0] out_q, out_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          full_q, full_d;
    logic          hold;

    // A stall only holds the register when it carries a live instruction;
    // a bubble may always be overwritten.
    assign hold = stall & valid_q;

    // Next-state: flush beats stall beats advance.
    always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        skid_d  = skid_q;
        full_d  = full_q;
        if (flush) begin
            valid_d = 1'b0;
            out_d   = '0;
            full_d  = 1'b0;
        end else if (hold) begin
            if (push) begin
                skid_d = data_in;
                full_d = 1'b1;
            end
        end else if (full_q) begin
            valid_d = 1'b1;
            out_d   = skid_q;
            if (push) begin
                skid_d = data_in;
            end else begin
                full_d = 1'b0;
            end
        end else if (push) begin
            valid_d = 1'b1;
            out_d   = data_in;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            out_q   <= '0;
            skid_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            full_q  <= full_d;
        end
    end

    assign valid     = valid_q;
    assign data_out  = out_q;
    assign skid_full = full_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding fetch controller
// and the instruction memory interface, feeding the IF/ID register.
//
// Memory handshake: a fetch is accepted in any cycle where imem_req and
// imem_ack are both high at the rising edge; imem_addr is held stable while
// imem_req waits for ack. The accepted fetch returns exactly one imem_rvalid
// pulse carrying imem_rdata, at least one cycle after acceptance. rvalid seen
// while no fetch is outstanding is ignored.
module fetch_stage
    import core_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               id_stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    branch_target,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc
);

    fetch_state_e              state_q, state_d;
    logic [PC_W-1:0]           pc_q, pc_d;
    logic [PC_W-1:0]           target_aligned;
    logic                      accept;
    logic                      deliver;
    logic                      skid_full;
    logic [INSTR_W+PC_W-1:0]   if_id_data;

    assign target_aligned = {branch_target[PC_W-1:2], 2'b00};
    assign accept         = imem_req & imem_ack;
    assign imem_addr      = pc_q;

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state and next PC; a flush always redirects the PC once fetching
    // has started, and an outstanding response is either consumed here or
    // remembered by KILL so it can be thrown away.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (flush) begin
                    pc_d = target_aligned;
                end else if (accept) begin
                    pc_d    = pc_q + PC_W'(INSTR_BYTES);
                    state_d = RESP;
                end
            end
            RESP: begin
                if (flush) begin
                    pc_d    = target_aligned;
                    state_d = imem_rvalid ? REQ : KILL;
                end else if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            KILL: begin
                if (flush) begin
                    pc_d = target_aligned;
                end
                // The killed response is the only one in flight; once it
                // lands nothing else can arrive, so fetching resumes.
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: request only while the skid has room, deliver live responses.
    always_comb begin
        imem_req = (state_q == REQ) & ~flush & ~skid_full;
        deliver  = (state_q == RESP) & imem_rvalid & ~flush;
    end

    if_id_skid #(
        .DW(INSTR_W + PC_W)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (deliver),
        .data_in  ({imem_rdata, pc_q - PC_W'(INSTR_BYTES)}),
        .stall    (id_stall),
        .flush    (flush),
        .valid    (id_valid),
        .data_out (if_id_data),
        .skid_full(skid_full)
    );

    assign {id_instr, id_pc} = if_id_data;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-programmable instruction memory plus a
// reference model that tracks which fetched words decode must see, in order.
module tb_fetch_stage;

    localparam int              PC_W     = 64;
    localparam int              INSTR_W  = 32;
    localparam logic [PC_W-1:0] RESET_PC = 64'h0;

    // ---------------- clock / reset ----------------
    logic               clk;
    logic               rst_n;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               id_stall;
    logic               flush;
    logic [PC_W-1:0]    branch_target;
    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic [PC_W-1:0]    id_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_stage #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_stall(id_stall), .flush(flush), .branch_target(branch_target),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc)
    );

    // ---------------- memory + reference model state ----------------
    typedef struct {
        logic [PC_W-1:0] addr;
        int              due;
        bit              live;
    } pend_t;

    pend_t                    pend_q[$];   // fetches accepted, response not yet returned
    logic [PC_W+INSTR_W-1:0]  exp_q[$];    // {pc, instr} delivered, not yet taken by decode
    logic [PC_W-1:0]          exp_pc;      // address the next request must carry
    logic [31:0]              salt;
    int                       cyc;
    int                       lat;         // 0 = random 1..3
    bit                       stray_en;
    int                       n_vec;
    int                       n_err;

    // Values sampled just before the last edge.
    logic                     s_req;
    logic [PC_W-1:0]          s_addr;
    logic [PC_W-1:0]          s_exp_pc;
    int                       s_qsize;
    bit                       s_acc;
    logic [PC_W-1:0]          s_acc_addr;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
        return a[31:0] ^ salt;
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic tick(input bit fl, input logic [PC_W-1:0] tgt, input bit st, input bit ak);
        bit resp;
        bit cons;
        int d;
        resp = (pend_q.size() != 0) && (pend_q[0].due == cyc);
        flush         = fl;
        branch_target = tgt;
        id_stall      = st;
        imem_ack      = ak;
        imem_rvalid   = resp || (stray_en && pend_q.size() == 0 && $urandom_range(0, 3) == 0);
        imem_rdata    = resp ? mem_word(pend_q[0].addr) : INSTR_W'($urandom);
        #1;
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_exp_pc = exp_pc;
        s_qsize  = exp_q.size();
        s_acc    = (s_req === 1'b1) && ak;
        s_acc_addr = exp_pc;
        cons     = (exp_q.size() != 0) && !st && !fl;
        @(posedge clk);
        if (!rst_n || fl) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].live = 1'b0;
        end else begin
            if (cons) void'(exp_q.pop_front());
            if (resp && pend_q[0].live)
                exp_q.push_back({pend_q[0].addr, mem_word(pend_q[0].addr)});
        end
        if (resp) void'(pend_q.pop_front());
        if (s_acc) begin
            d = (lat == 0) ? int'($urandom_range(1, 3)) : lat;
            pend_q.push_back('{addr: exp_pc, due: cyc + d, live: (rst_n === 1'b1)});
            if (rst_n) exp_pc = exp_pc + 64'd4;
        end
        if (!rst_n) exp_pc = RESET_PC;
        else if (fl) exp_pc = {tgt[PC_W-1:2], 2'b00};
        #1;
        cyc++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick(0, '0, 0, 0);
        tick(0, '0, 0, 0);
        rst_n = 1'b1;
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        n_vec++; if (id_instr !== '0) begin n_err++; $display("FAIL reset_instr: got %h want 0", id_instr); end
        n_vec++; if (id_pc !== '0) begin n_err++; $display("FAIL reset_pc: got %h want 0", id_pc); end
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_vec++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        logic [PC_W-1:0] seen[$];
        bit prev_valid;
        prev_valid = 1'b0;
        salt = 32'h0;
        lat  = 1;
        for (int i = 0; i < 11; i++) begin
            tick(0, '0, 0, 1);
            n_vec++; if (id_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL seq_valid: got %b want %b", id_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                n_vec++; if ({id_pc, id_instr} !== exp_q[0]) begin n_err++; $display("FAIL seq_word: got %h/%h want %h", id_pc, id_instr, exp_q[0]); end
            end
            if (s_req === 1'b1) begin
                n_vec++; if (s_addr !== s_exp_pc) begin n_err++; $display("FAIL seq_addr: got %h want %h", s_addr, s_exp_pc); end
            end
            n_vec++; if (prev_valid && id_valid === 1'b1) begin n_err++; $display("FAIL seq_rate: id_valid high two cycles running at cycle %0d, want alternate", cyc); end
            if (id_valid === 1'b1) seen.push_back(id_pc);
            prev_valid = (id_valid === 1'b1);
        end
        n_vec++;
        if (seen.size() < 4) begin
            n_err++; $display("FAIL seq_count: got %0d words want >= 4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (seen[i] !== 64'(4 * i)) begin n_err++; $display("FAIL seq_order: word %0d pc %h want %h", i, seen[i], 64'(4 * i)); end
                if (mem_word(seen[i]) !== seen[i][31:0]) begin n_err++; $display("FAIL seq_mem: word %0d data rule broken", i); end
            end
        end
    endtask

    task automatic test_stall();
        logic [PC_W+INSTR_W-1:0] held;
        bit found;
        found = 1'b0;
        salt = $urandom;
        lat  = 1;
        for (int i = 0; i < 8 && !found; i++) begin
            tick(0, '0, 0, 1);
            found = (id_valid === 1'b1);
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL stall_setup: id_valid never rose, want 1"); end
        held = {id_pc, id_instr};
        for (int i = 0; i < 5; i++) begin
            tick(0, '0, 1, 1);
            n_vec++; if ({id_pc, id_instr} !== held || id_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold: got %b %h want 1 %h", id_valid, {id_pc, id_instr}, held); end
            if (s_qsize >= 2) begin
                n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL stall_req: got req %b with skid full want 0", s_req); end
            end
        end
        n_vec++; if (exp_q.size() != 2 || imem_req !== 1'b0) begin n_err++; $display("FAIL stall_skid: model depth %0d req %b want 2 and 0", exp_q.size(), imem_req); end
        for (int i = 0; i < 8; i++) begin
            tick(0, '0, 0, 1);
            n_vec++; if (id_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL stall_valid: got %b want %b", id_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                n_vec++; if ({id_pc, id_instr} !== exp_q[0]) begin n_err++; $display("FAIL stall_word: got %h/%h want %h", id_pc, id_instr, exp_q[0]); end
            end
        end
    endtask

    task automatic test_flush_resp();
        bit found;
        found = 1'b0;
        lat = 3;
        for (int i = 0; i < 8 && !found; i++) begin
            tick(0, '0, 0, 1);
            found = s_acc;
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL fresp_setup: no fetch accepted, want one"); end
        lat = 1;
        tick(1, 64'h100, 0, 1);
        n_vec++; if (id_valid !== 1'b0 || id_instr !== '0) begin n_err++; $display("FAIL fresp_kill: got %b %h want 0 0", id_valid, id_instr); end
        for (int i = 0; i < 2; i++) begin
            tick(0, '0, 0, 1);
            n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL fresp_bubble: got %b want 0", id_valid); end
        end
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick(0, '0, 0, 1);
            found = (id_valid === 1'b1);
        end
        n_vec++; if (!found || id_pc !== 64'h100 || id_instr !== mem_word(64'h100)) begin n_err++; $display("FAIL fresp_target: got %b %h/%h want 1 100/%h", id_valid, id_pc, id_instr, mem_word(64'h100)); end
    endtask

    task automatic test_flush_rvalid();
        bit found;
        found = 1'b0;
        lat = 1;
        for (int i = 0; i < 8 && !found; i++) begin
            tick(0, '0, 0, 1);
            found = s_acc;
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL frv_setup: no fetch accepted, want one"); end
        tick(1, 64'h100, 0, 1);
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL frv_drop: got %b want 0", id_valid); end
        tick(0, '0, 0, 1);
        n_vec++; if (s_req !== 1'b1 || s_addr !== 64'h100) begin n_err++; $display("FAIL frv_addr: got req %b addr %h want 1 100", s_req, s_addr); end
        tick(1, 64'h103, 0, 1);
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL frv_drop2: got %b want 0", id_valid); end
        tick(0, '0, 0, 1);
        n_vec++; if (s_req !== 1'b1 || s_addr !== 64'h100) begin n_err++; $display("FAIL frv_align: got req %b addr %h want 1 100", s_req, s_addr); end
        tick(0, '0, 0, 1);
        n_vec++; if (id_valid !== 1'b1 || id_pc !== 64'h100) begin n_err++; $display("FAIL frv_word: got %b %h want 1 100", id_valid, id_pc); end
    endtask

    task automatic test_ack_hold();
        logic [PC_W-1:0] a0;
        logic [PC_W-1:0] accs[$];
        bit found;
        found = 1'b0;
        lat = 1;
        for (int i = 0; i < 8 && !found; i++) begin
            tick(0, '0, 0, 0);
            found = (imem_req === 1'b1);
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL ack_setup: imem_req never rose, want 1"); end
        a0 = imem_addr;
        for (int i = 0; i < 3; i++) begin
            tick(0, '0, 0, 0);
            n_vec++; if (s_req !== 1'b1 || s_addr !== a0 || imem_addr !== a0) begin n_err++; $display("FAIL ack_hold: got req %b addr %h want 1 %h", s_req, s_addr, a0); end
        end
        tick(0, '0, 0, 1);
        n_vec++; if (!s_acc || imem_addr !== a0 + 64'd4) begin n_err++; $display("FAIL ack_accept: got pc %h want %h", imem_addr, a0 + 64'd4); end
        tick(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1);
        for (int i = 0; i < 12 && accs.size() < 2; i++) begin
            tick(0, '0, 0, 1);
            if (s_acc) accs.push_back(s_addr);
            if (exp_q.size() != 0) begin
                n_vec++; if ({id_pc, id_instr} !== exp_q[0]) begin n_err++; $display("FAIL wrap_word: got %h/%h want %h", id_pc, id_instr, exp_q[0]); end
            end
        end
        n_vec++;
        if (accs.size() < 2) begin
            n_err++; $display("FAIL wrap_count: got %0d fetches want 2", accs.size());
        end else if (accs[0] !== 64'hFFFF_FFFF_FFFF_FFFC || accs[1] !== 64'h0) begin
            n_err++; $display("FAIL wrap_addr: got %h then %h want fffffffffffffffc then 0", accs[0], accs[1]);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        lat = 2;
        for (int i = 0; i < 8 && !found; i++) begin
            tick(0, '0, 0, 1);
            found = s_acc;
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL rmid_setup: no fetch accepted, want one"); end
        rst_n = 1'b0;
        tick(0, '0, 0, 0);
        rst_n = 1'b1;
        n_vec++; if (id_valid !== 1'b0 || id_instr !== '0 || id_pc !== '0 || imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_state: got %b %h %h req %b want 0 0 0 0", id_valid, id_instr, id_pc, imem_req); end
        lat = 1;
        tick(0, '0, 0, 1);
        n_vec++; if (id_valid !== 1'b0 || s_req !== 1'b0) begin n_err++; $display("FAIL rmid_stray: got valid %b req %b want 0 0", id_valid, s_req); end
        tick(0, '0, 0, 1);
        n_vec++; if (!s_acc || s_addr !== RESET_PC) begin n_err++; $display("FAIL rmid_first: got acc %b addr %h want 1 %h", s_acc, s_addr, RESET_PC); end
        tick(0, '0, 0, 1);
        n_vec++; if (id_valid !== 1'b1 || id_pc !== RESET_PC || id_instr !== mem_word(RESET_PC)) begin n_err++; $display("FAIL rmid_word: got %b %h/%h want 1 %h/%h", id_valid, id_pc, id_instr, RESET_PC, mem_word(RESET_PC)); end
    endtask

    task automatic test_random();
        bit fl, st, ak;
        logic [PC_W-1:0] tgt;
        bit done;
        salt     = $urandom;
        lat      = 0;
        stray_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            fl  = ($urandom_range(0, 15) == 0);
            tgt = {$urandom, $urandom};
            st  = ($urandom_range(0, 2) == 0);
            ak  = ($urandom_range(0, 2) != 0);
            tick(fl, tgt, st, ak);
            n_vec++; if (id_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rnd_valid: cycle %0d got %b want %b", cyc, id_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                n_vec++; if ({id_pc, id_instr} !== exp_q[0]) begin n_err++; $display("FAIL rnd_word: cycle %0d got %h/%h want %h", cyc, id_pc, id_instr, exp_q[0]); end
            end
            if (s_req === 1'b1) begin
                n_vec++; if (s_addr !== s_exp_pc) begin n_err++; $display("FAIL rnd_addr: cycle %0d got %h want %h", cyc, s_addr, s_exp_pc); end
            end
            if (fl || s_qsize >= 2) begin
                n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL rnd_block: cycle %0d got req %b want 0", cyc, s_req); end
            end
        end
        stray_en = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            tick(0, '0, 0, 0);
            if (exp_q.size() != 0) begin
                n_vec++; if ({id_pc, id_instr} !== exp_q[0]) begin n_err++; $display("FAIL rnd_drain_word: got %h/%h want %h", id_pc, id_instr, exp_q[0]); end
            end
            done = (exp_q.size() == 0) && (pend_q.size() == 0);
        end
        n_vec++; if (!done || id_valid !== 1'b0) begin n_err++; $display("FAIL rnd_drain: pending %0d valid %b want all drained and 0", exp_q.size() + pend_q.size(), id_valid); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_vec = 0; n_err = 0; cyc = 0; lat = 1; stray_en = 1'b0; salt = 32'h0;
        exp_pc = RESET_PC;
        rst_n = 1'b0; imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        id_stall = 1'b0; flush = 1'b0; branch_target = '0;
        @(posedge clk); #1;
        test_reset();
        test_sequential();
        test_stall();
        test_flush_resp();
        test_flush_rvalid();
        test_ack_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
